booth_seq_mul: RTL and testbench
================================

# booth_seq_mul

Iterative radix-4 Booth multiplier that produces one partial product per cycle and accumulates it in carry-save form through the team's `csa` 3-2 carry-save adder. After the last partial product it resolves sum and carry with a single carry-propagate add. It sits directly upstream of `csa`, supplying its three operands every cycle, and consumes its `sum`/`carry` outputs. It serves as the mantissa multiplier for the FP datapath, with a valid/ready handshake on both sides.

## Interface
- `W`, default 24: unsigned operand width; must be even.
- `clk`  input  1: clock, rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: operands presented.
- `in_ready`  output  1: block can accept operands; high only in IDLE.
- `a`  input  W: multiplicand, unsigned.
- `b`  input  W: multiplier, unsigned; Booth-recoded.
- `out_valid`  output  1: `product` valid; held until accepted.
- `out_ready`  input  1: consumer accepts `product`.
- `product`  output  2W: a*b, unsigned.

## Operation
- Derived widths:
  - `N_PP = (W+2)/2`, which is 13 for W=24. `b` is zero-extended by 2 bits so the top digit is never negative.
  - `ACC_W = 2W+2`. All accumulation is modulo 2^ACC_W.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
  - IDLE: on `in_valid`, latch `a` and `b`, clear `sum_r`/`carry_r`, set `idx`=0, go to ACCUM.
  - ACCUM: recode digit `idx` from bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0. The digit is one of {-2,-1,0,+1,+2}.
  - ACCUM: the partial product is `pp` = digit*a << 2i, in full two's complement, sign-extended to ACC_W.
  - ACCUM: drive `csa(pp0=sum_r, pp1=carry_r, pp2=pp)` and register `sum_r`←`sum` and `carry_r`←`carry`<<1, truncated to ACC_W. Increment `idx`. When `idx`==N_PP-1, go to RESOLVE.
  - RESOLVE: `product`←(`sum_r`+`carry_r`)[2W-1:0], then go to DONE.
  - DONE: `out_valid`=1. When `out_ready` is high, go to IDLE.
- Truncating to 2W bits is exact because a*b < 2^2W.
- `in_ready` = (state==IDLE). In DONE, an `in_valid` is not accepted until the cycle after IDLE is re-entered.
- `product` holds its value until the next RESOLVE. It is not cleared on handshake.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `sum_r`=`carry_r`=0, `idx`=0.
- Reset mid-operation aborts the operation with no output. The first operation after reset starts cleanly.

## Timing
- Operands are accepted at edge E0.
- Edges E1..E(N_PP) perform accumulation.
- Edge E(N_PP+1) registers `product`, and `out_valid` is high from that edge.
- Latency is N_PP+1 cycles from acceptance to `out_valid`, which is 14 for W=24.
- Throughput is one result per N_PP+3 cycles, assuming `out_ready` is held high and `in_valid` is continuously asserted.
- `product`, `out_valid` and `in_ready` are all registered or state-decoded. There is no combinational path from `in_valid` or `out_ready` to any output.
- `a` and `b` may change after acceptance without affecting the result.

## Structure
- Package `mul_pkg`:
  - localparams `N_PP` and `ACC_W` as functions of W.
  - state enum `mul_state_t` {IDLE, ACCUM, RESOLVE, DONE}.
  - Booth digit type: 3-bit one-hot magnitude {zero, one, two} plus a `neg` bit.
- Sub-module `booth_pp_gen`: combinational. Inputs are `a`, the 3-bit Booth window and `idx`. Output is the ACC_W-bit partial product.
- The top level holds the FSM, `idx` counter, registers, the `csa #(.Num(ACC_W))` instance and the final adder.

## Test plan
- a=3, b=5 → `out_valid` exactly 14 cycles after acceptance, `product`=15.
- a=0xFFFFFF, b=0xFFFFFF → `product`=0xFFFFFE000001.
- a=0x800000, b=0xAAAAAA, which produces repeated −2/−1 digits → `product`=0x555555000000.
- a=0, b=0x123456, and separately a=0x123456, b=0 → `product`=0 in both cases.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles → `out_valid` and `product` are stable, and `in_ready`=0 throughout.
  - Raise `out_ready` → `in_ready`=1 on the next cycle.
  - A new `in_valid` presented during DONE is accepted only after the return to IDLE.
- Assert `rst_n`=0 at ACCUM `idx`=6 → all outputs take their reset values immediately.
  - Then start a=7, b=9 → `product`=63 with normal latency and no residue from the aborted operation.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, width helpers and Booth decode for booth_seq_mul
package mul_pkg;

  // Width helpers. A package cannot take parameters, so the derived
  // widths are computed from the operand width W by these functions.
  function automatic int n_pp_f(input int w);
    return (w + 2) / 2;
  endfunction

  function automatic int acc_w_f(input int w);
    return 2 * w + 2;
  endfunction

  localparam int W_DEF     = 24;
  localparam int N_PP_DEF  = n_pp_f(W_DEF);
  localparam int ACC_W_DEF = acc_w_f(W_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } mul_state_t;

  // Booth digit: one-hot magnitude {two, one, zero} plus a sign bit.
  localparam logic [2:0] MAG_ZERO = 3'b001;
  localparam logic [2:0] MAG_ONE  = 3'b010;
  localparam logic [2:0] MAG_TWO  = 3'b100;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } booth_digit_t;

  // Radix-4 recoding of the window {b[2i+1], b[2i], b[2i-1]}.
  // 3'b111 is -0; it is reported as plain zero so no negation happens.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    d.neg = 1'b0;
    d.mag = MAG_ZERO;
    case (win)
      3'b001, 3'b010: begin d.neg = 1'b0; d.mag = MAG_ONE; end
      3'b011:         begin d.neg = 1'b0; d.mag = MAG_TWO; end
      3'b100:         begin d.neg = 1'b1; d.mag = MAG_TWO; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.mag = MAG_ONE; end
      default:        begin d.neg = 1'b0; d.mag = MAG_ZERO; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - radix-4 Booth partial product for one digit position
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int W     = 24,
  parameter int ACC_W = 2 * W + 2,
  parameter int IDX_W = 4
) (
  input  logic [W-1:0]     a,
  input  logic [2:0]       window,
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] pp
);

  booth_digit_t     w_digit;
  logic [ACC_W-1:0] w_mag;
  logic [ACC_W-1:0] w_shifted;

  // Select |digit|*a, align to weight 4^idx, then negate modulo 2^ACC_W.
  always_comb begin
    w_digit = booth_decode(window);
    w_mag   = '0;
    if (w_digit.mag == MAG_ONE) begin
      w_mag = ACC_W'(a);
    end else if (w_digit.mag == MAG_TWO) begin
      w_mag = ACC_W'({a, 1'b0});
    end
    w_shifted = w_mag << {idx, 1'b0};
    pp        = w_digit.neg ? (~w_shifted + ACC_W'(1)) : w_shifted;
  end

endmodule

// File: rtl/csa.sv
// rtl/csa.sv - bitwise 3-2 carry-save adder
module csa #(
  parameter int Num = 8
) (
  input  logic [Num-1:0] pp0,
  input  logic [Num-1:0] pp1,
  input  logic [Num-1:0] pp2,
  output logic [Num-1:0] sum,
  output logic [Num-1:0] carry
);

  // Per-bit full adder; carry is unshifted, the caller aligns it.
  always_comb begin
    sum   = pp0 ^ pp1 ^ pp2;
    carry = (pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2);
  end

endmodule

// File: rtl/booth_seq_mul.sv
// rtl/booth_seq_mul.sv - iterative radix-4 Booth multiplier with carry-save accumulation
module booth_seq_mul
  import mul_pkg::*;
#(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
);

  localparam int N_PP  = n_pp_f(W);
  localparam int ACC_W = acc_w_f(W);
  localparam int IDX_W = $clog2(N_PP + 1);

  mul_state_t       r_state;
  mul_state_t       w_next_state;

  logic [W-1:0]     r_a;
  logic [W+2:0]     r_b_ext;     // {2'b00, b, 1'b0}: b[-1]=0 and two zero guard bits
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [2*W-1:0]   r_product;

  logic [W+2:0]     w_b_shift;
  logic [2:0]       w_window;
  logic [ACC_W-1:0] w_pp;
  logic [ACC_W-1:0] w_csa_sum;
  logic [ACC_W-1:0] w_csa_carry;
  logic [ACC_W-1:0] w_resolved;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

  // Booth window for the current digit and end-of-accumulation flag.
  always_comb begin
    w_b_shift  = r_b_ext >> {r_idx, 1'b0};
    w_window   = w_b_shift[2:0];
    w_last     = (r_idx == IDX_W'(N_PP - 1));
    w_resolved = r_sum + r_carry;
  end

  booth_pp_gen #(
    .W     (W),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_pp_gen (
    .a      (r_a),
    .window (w_window),
    .idx    (r_idx),
    .pp     (w_pp)
  );

  csa #(
    .Num (ACC_W)
  ) u_csa (
    .pp0   (r_sum),
    .pp1   (r_carry),
    .pp2   (w_pp),
    .sum   (w_csa_sum),
    .carry (w_csa_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = ACCUM;
      ACCUM:   if (w_last)    w_next_state = RESOLVE;
      RESOLVE:                w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, carry-save accumulation and the final resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b_ext   <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_idx     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b_ext <= {2'b00, b, 1'b0};
            r_sum   <= '0;
            r_carry <= '0;
            r_idx   <= '0;
          end
        end
        ACCUM: begin
          r_sum   <= w_csa_sum;
          r_carry <= {w_csa_carry[ACC_W-2:0], 1'b0};
          r_idx   <= r_idx + IDX_W'(1);
        end
        RESOLVE: begin
          // a*b < 2^(2W), so dropping the top two accumulator bits is exact.
          r_product <= w_resolved[2*W-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb/tb_booth_seq_mul.sv - directed table-driven bench for booth_seq_mul
module tb_booth_seq_mul;

  localparam int W       = 24;
  localparam int LATENCY = 14;
  localparam int TIMEOUT = 40;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp;
  } vec_t;

  booth_seq_mul #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present operands just after an edge; acceptance happens on the next edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  // Count edges from acceptance until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];
  int   lat;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{24'd3,      24'd5,      48'd15};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[2] = '{24'h800000, 24'hAAAAAA, 48'h555555000000};
    vecs[3] = '{24'h000000, 24'h123456, 48'h0};
    vecs[4] = '{24'h123456, 24'h000000, 48'h0};
    vecs[5] = '{24'd1,      24'd1,      48'd1};
    vecs[6] = '{24'hFFFFFF, 24'd1,      48'hFFFFFF};
    vecs[7] = '{24'd2,      24'h800000, 48'h1000000};
    vecs[8] = '{24'h555555, 24'd3,      48'hFFFFFF};
    vecs[9] = '{24'h001000, 24'h001000, 48'h1000000};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product",   64'(product),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].va, vecs[i].vb);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LATENCY));
      check($sformatf("vec%0d_product", i), 64'(product), 64'(vecs[i].exp));
      accept_out();
      check($sformatf("vec%0d_idle_ready", i), 64'(in_ready), 64'd1);
      check($sformatf("vec%0d_idle_nvalid", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: hold out_ready low in DONE while a new request waits.
    start_op(24'd5, 24'd6);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(LATENCY));
    in_valid = 1'b1;
    a        = 24'd2;
    b        = 24'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_product", c), 64'(product), 64'd30);
      check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_product", 64'(product), 64'd30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    check("bp_new_accepted", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("bp_new_latency", 64'(lat), 64'(LATENCY));
    check("bp_new_product", 64'(product), 64'd6);
    accept_out();

    // Reset in the middle of accumulation, at idx 6.
    start_op(24'h123456, 24'h654321);
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product",   64'(product),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(24'd7, 24'd9);
    wait_valid(lat);
    check("post_reset_latency", 64'(lat), 64'(LATENCY));
    check("post_reset_product", 64'(product), 64'd63);
    accept_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
